cache_controller: RTL and testbench
===================================

Name: cache_controller

Overview:
- Sits between the MEM pipeline stage and the 2-way data cache / 64-bit SRAM path.
- Serves read hits from the cache in the same cycle.
- On a read miss, fetches the 64-bit line from SRAM, drives the cache update enable and returns the requested word.
- Writes are write-through with invalidate. The block stalls the pipeline via `ready` while any SRAM access is outstanding, and keeps saturating hit/miss counters.

Parameters:
- CNT_WIDTH, 16, width of hit_count and miss_count.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- mem_r_en  in  1  load request from MEM stage
- mem_w_en  in  1  store request from MEM stage
- address  in  32  byte address of request, held by pipeline while ready=0
- write_data  in  32  store data
- cache_hit  in  1  hit flag from cache for current cache_address
- cache_data  in  32  hit data from cache
- cache_address  out  32  address presented to cache
- cache_u_en  out  1  cache line fill enable (cache captures sram_read_data on this edge)
- cache_invalid  out  1  invalidate matching cache line
- sram_r_en  out  1  SRAM 64-bit read strobe
- sram_w_en  out  1  SRAM 32-bit write strobe
- sram_address  out  32  SRAM address
- sram_write_data  out  32  SRAM write data
- sram_ready  in  1  SRAM completion pulse, one cycle
- sram_read_data  in  64  SRAM line; [63:32] = word at offset 0, [31:0] = word at offset 4
- read_data  out  32  load result, valid when ready=1 and mem_r_en=1
- ready  out  1  1 = pipeline may advance; 0 = freeze
- hit_count  out  CNT_WIDTH  read hits since reset, saturating
- miss_count  out  CNT_WIDTH  read misses since reset, saturating

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; req_addr/req_wdata=0; counters=0.
  - sram_r_en, sram_w_en, cache_u_en, cache_invalid = 0.
  - read_data=0; ready=1.
- States: IDLE, READ_MISS, WRITE.
- Request priority: mem_w_en wins if both request inputs are high; the read is ignored.
- IDLE:
  - cache_address=address.
  - No request: ready=1, read_data=0, next IDLE.
  - mem_r_en & cache_hit: read_data=cache_data, ready=1 combinationally; hit_count+1; next IDLE.
  - mem_r_en & !cache_hit: ready=0; latch req_addr=address; miss_count+1; next READ_MISS.
  - mem_w_en: ready=0; cache_invalid=cache_hit for this cycle only; latch req_addr and req_wdata; next WRITE.
- READ_MISS:
  - cache_address=req_addr.
  - sram_r_en=1; sram_address={req_addr[31:3],3'b000}.
  - Outputs hold until sram_ready=1. In that cycle:
    - cache_u_en=1 for exactly that cycle.
    - read_data = req_addr[2] ? sram_read_data[31:0] : sram_read_data[63:32].
    - ready=1; next IDLE.
  - sram_r_en drops the cycle after sram_ready.
- WRITE:
  - cache_address=req_addr.
  - sram_w_en=1; sram_address=req_addr; sram_write_data=req_wdata.
  - On sram_ready: ready=1; next IDLE.
- sram_ready in IDLE is ignored.
- No timeout: the block waits indefinitely for sram_ready.
- Back-to-back operation: a new request in the cycle after returning to IDLE is accepted normally. After a fill, the following read of the same line must hit.
- Counters:
  - Increment only on acceptance in IDLE.
  - Hold at 2^CNT_WIDTH-1.
  - Not incremented by writes.
- Reset during READ_MISS or WRITE:
  - Strobes drop immediately (async) and state returns to IDLE.
  - No cache_u_en is issued for the aborted access.
- cache_u_en and cache_invalid are never high in the same cycle.

Test Plan:
- Reset then idle: rst=0 -> all strobes 0, ready=1, counters 0. Release rst with no requests -> ready stays 1.
- Read hit: mem_r_en=1, address=0x400, cache_hit=1, cache_data=0xDEADBEEF -> same cycle read_data=0xDEADBEEF, ready=1, hit_count=1, sram_r_en never asserted.
- Read miss: mem_r_en=1, address=0x40C, cache_hit=0; SRAM returns sram_ready 6 cycles later with sram_read_data=0x11111111_22222222.
  - Required: next cycle sram_r_en=1 and sram_address=0x408.
  - Ready cycle: cache_u_en=1 for 1 cycle, read_data=0x22222222, ready=1; miss_count=1.
  - ready=0 for exactly 6 cycles.
- Store on hit: mem_w_en=1, address=0x410, write_data=0xA5A5A5A5, cache_hit=1.
  - Required: cache_invalid=1 in acceptance cycle only.
  - Then sram_w_en=1, sram_address=0x410, sram_write_data=0xA5A5A5A5 until sram_ready; ready=1 on that cycle.
  - Counters unchanged.
- Simultaneous mem_r_en=mem_w_en=1 -> WRITE path taken; no sram_r_en, no counter change.
- Reset mid-miss: rst=0 asserted 3 cycles into READ_MISS -> sram_r_en=0 asynchronously, state IDLE, no cache_u_en. After release, the same read request restarts the miss with miss_count=1.
- Saturation: CNT_WIDTH=2, 5 read hits -> hit_count=3.

Source files
------------

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - MEM-stage cache controller: read hits, line fills on miss, write-through with invalidate
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   mem_r_en, mem_w_en        load / store request from the MEM stage (store wins if both high)
//   address, write_data       request byte address and store data (held by the pipeline while ready=0)
//   cache_hit, cache_data     hit flag and data from the 2-way cache for cache_address
//   cache_address             address presented to the cache
//   cache_u_en                line fill enable (cache captures sram_read_data)
//   cache_invalid             invalidate the matching cache line
//   sram_r_en, sram_w_en      SRAM 64-bit read / 32-bit write strobes
//   sram_address              SRAM address
//   sram_write_data           SRAM write data
//   sram_ready                SRAM completion pulse
//   sram_read_data            64-bit line, [63:32] = word at offset 0, [31:0] = word at offset 4
//   read_data                 load result, valid when ready=1 and mem_r_en=1
//   ready                     1 = pipeline may advance, 0 = freeze
//   hit_count, miss_count     saturating read hit / miss counters
module cache_controller #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mem_r_en,
   input  logic                 mem_w_en,
   input  logic [31:0]          address,
   input  logic [31:0]          write_data,
   input  logic                 cache_hit,
   input  logic [31:0]          cache_data,
   output logic [31:0]          cache_address,
   output logic                 cache_u_en,
   output logic                 cache_invalid,
   output logic                 sram_r_en,
   output logic                 sram_w_en,
   output logic [31:0]          sram_address,
   output logic [31:0]          sram_write_data,
   input  logic                 sram_ready,
   input  logic [63:0]          sram_read_data,
   output logic [31:0]          read_data,
   output logic                 ready,
   output logic [CNT_WIDTH-1:0] hit_count,
   output logic [CNT_WIDTH-1:0] miss_count
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      READ_MISS = 2'd1,
      WRITE     = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   // Acceptance decode in IDLE; a store masks a simultaneous load.
   logic        take_write;
   logic        take_hit;
   logic        take_miss;

   assign take_write = (state == IDLE) && mem_w_en;
   assign take_hit   = (state == IDLE) && !mem_w_en && mem_r_en && cache_hit;
   assign take_miss  = (state == IDLE) && !mem_w_en && mem_r_en && !cache_hit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         req_addr   <= '0;
         req_wdata  <= '0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         state <= state_next;
         if (take_write) begin
            req_addr  <= address;
            req_wdata <= write_data;
         end
         if (take_miss) begin
            req_addr <= address;
            if (miss_count != {CNT_WIDTH{1'b1}})
               miss_count <= miss_count + 1'b1;
         end
         if (take_hit && (hit_count != {CNT_WIDTH{1'b1}}))
            hit_count <= hit_count + 1'b1;
      end
   end

   always_comb begin
      state_next      = state;
      cache_address   = address;
      cache_u_en      = 1'b0;
      cache_invalid   = 1'b0;
      sram_r_en       = 1'b0;
      sram_w_en       = 1'b0;
      sram_address    = '0;
      sram_write_data = '0;
      read_data       = '0;
      ready           = 1'b1;
      // Outputs are forced quiet while reset is held so an aborted access
      // cannot leak a strobe or a fill enable.
      if (rst) begin
         case (state)
            IDLE: begin
               if (mem_w_en) begin
                  ready         = 1'b0;
                  cache_invalid = cache_hit;
                  state_next    = WRITE;
               end else if (mem_r_en) begin
                  if (cache_hit) begin
                     read_data = cache_data;
                  end else begin
                     ready      = 1'b0;
                     state_next = READ_MISS;
                  end
               end
            end
            READ_MISS: begin
               cache_address = req_addr;
               sram_r_en     = 1'b1;
               sram_address  = {req_addr[31:3], 3'b000};
               ready         = 1'b0;
               if (sram_ready) begin
                  cache_u_en = 1'b1;
                  read_data  = req_addr[2] ? sram_read_data[31:0] : sram_read_data[63:32];
                  ready      = 1'b1;
                  state_next = IDLE;
               end
            end
            WRITE: begin
               cache_address   = req_addr;
               sram_w_en       = 1'b1;
               sram_address    = req_addr;
               sram_write_data = req_wdata;
               ready           = 1'b0;
               if (sram_ready) begin
                  ready      = 1'b1;
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - directed table-driven bench for cache_controller
module tb_cache_controller;

   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          mem_r_en, mem_w_en;
   logic [31:0]   address, write_data;
   logic          cache_hit;
   logic [31:0]   cache_data;
   logic [31:0]   cache_address;
   logic          cache_u_en, cache_invalid;
   logic          sram_r_en, sram_w_en;
   logic [31:0]   sram_address, sram_write_data;
   logic          sram_ready;
   logic [63:0]   sram_read_data;
   logic [31:0]   read_data;
   logic          ready;
   logic [CW-1:0] hit_count, miss_count;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   cache_controller #(.CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst),
      .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
      .address(address), .write_data(write_data),
      .cache_hit(cache_hit), .cache_data(cache_data),
      .cache_address(cache_address), .cache_u_en(cache_u_en), .cache_invalid(cache_invalid),
      .sram_r_en(sram_r_en), .sram_w_en(sram_w_en),
      .sram_address(sram_address), .sram_write_data(sram_write_data),
      .sram_ready(sram_ready), .sram_read_data(sram_read_data),
      .read_data(read_data), .ready(ready),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   typedef struct packed {
      // stimulus
      logic          r;
      logic          w;
      logic [31:0]   addr;
      logic [31:0]   wd;
      logic          hit;
      logic [31:0]   cdata;
      logic          srdy;
      logic [63:0]   srdata;
      // expected, sampled before the rising edge of the same cycle
      logic          e_ready;
      logic [31:0]   e_rdata;
      logic [31:0]   e_caddr;
      logic          e_sr;
      logic          e_sw;
      logic [31:0]   e_saddr;
      logic [31:0]   e_swd;
      logic          e_uen;
      logic          e_inv;
      logic [CW-1:0] e_hc;
      logic [CW-1:0] e_mc;
   } vec_t;

   localparam int NV = 18;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      mem_r_en = 0; mem_w_en = 0; address = 0; write_data = 0;
      cache_hit = 0; cache_data = 0; sram_ready = 0; sram_read_data = 0;
   endtask

   initial begin
      //         r  w  addr       wd           hit cdata        srdy srdata                   | rdy rdata       caddr      sr sw saddr      swd          uen inv hc mc
      vecs[0]  = '{0, 0, 32'h0,   32'h0,       0, 32'h0,        0, 64'h0,                    1, 32'h0,        32'h0,   0, 0, 32'h0,   32'h0,       0, 0, 2'd0, 2'd0};
      vecs[1]  = '{1, 0, 32'h400, 32'h0,       1, 32'hDEADBEEF, 0, 64'h0,                    1, 32'hDEADBEEF, 32'h400, 0, 0, 32'h0,   32'h0,       0, 0, 2'd0, 2'd0};
      vecs[2]  = '{0, 0, 32'h400, 32'h0,       0, 32'h0,        0, 64'h0,                    1, 32'h0,        32'h400, 0, 0, 32'h0,   32'h0,       0, 0, 2'd1, 2'd0};
      vecs[3]  = '{1, 0, 32'h40C, 32'h0,       0, 32'h0,        0, 64'h0,                    0, 32'h0,        32'h40C, 0, 0, 32'h0,   32'h0,       0, 0, 2'd1, 2'd0};
      vecs[4]  = '{1, 0, 32'h40C, 32'h0,       0, 32'h0,        0, 64'h0,                    0, 32'h0,        32'h40C, 1, 0, 32'h408, 32'h0,       0, 0, 2'd1, 2'd1};
      vecs[5]  = vecs[4];
      vecs[6]  = vecs[4];
      vecs[7]  = vecs[4];
      vecs[8]  = vecs[4];
      vecs[9]  = '{1, 0, 32'h40C, 32'h0,       0, 32'h0,        1, 64'h11111111_22222222,   1, 32'h22222222, 32'h40C, 1, 0, 32'h408, 32'h0,       1, 0, 2'd1, 2'd1};
      vecs[10] = '{1, 0, 32'h408, 32'h0,       1, 32'h22222222, 0, 64'h0,                    1, 32'h22222222, 32'h408, 0, 0, 32'h0,   32'h0,       0, 0, 2'd1, 2'd1};
      vecs[11] = '{0, 1, 32'h410, 32'hA5A5A5A5, 1, 32'h0,       0, 64'h0,                    0, 32'h0,        32'h410, 0, 0, 32'h0,   32'h0,       0, 1, 2'd2, 2'd1};
      vecs[12] = '{0, 1, 32'h410, 32'hA5A5A5A5, 1, 32'h0,       0, 64'h0,                    0, 32'h0,        32'h410, 0, 1, 32'h410, 32'hA5A5A5A5, 0, 0, 2'd2, 2'd1};
      vecs[13] = '{0, 1, 32'h410, 32'hA5A5A5A5, 1, 32'h0,       1, 64'h0,                    1, 32'h0,        32'h410, 0, 1, 32'h410, 32'hA5A5A5A5, 0, 0, 2'd2, 2'd1};
      vecs[14] = '{1, 1, 32'h500, 32'h12345678, 0, 32'h0,       0, 64'h0,                    0, 32'h0,        32'h500, 0, 0, 32'h0,   32'h0,       0, 0, 2'd2, 2'd1};
      vecs[15] = '{1, 1, 32'h500, 32'h12345678, 0, 32'h0,       0, 64'h0,                    0, 32'h0,        32'h500, 0, 1, 32'h500, 32'h12345678, 0, 0, 2'd2, 2'd1};
      vecs[16] = '{1, 1, 32'h500, 32'h12345678, 0, 32'h0,       1, 64'h0,                    1, 32'h0,        32'h500, 0, 1, 32'h500, 32'h12345678, 0, 0, 2'd2, 2'd1};
      vecs[17] = '{0, 0, 32'h0,   32'h0,       0, 32'h0,        1, 64'hFFFFFFFF_FFFFFFFF,   1, 32'h0,        32'h0,   0, 0, 32'h0,   32'h0,       0, 0, 2'd2, 2'd1};

      // reset held across an edge
      rst = 1'b0;
      idle_inputs();
      step();
      chk("rst_ready", ready, 1);
      chk("rst_sram_r_en", sram_r_en, 0);
      chk("rst_sram_w_en", sram_w_en, 0);
      chk("rst_cache_u_en", cache_u_en, 0);
      chk("rst_cache_invalid", cache_invalid, 0);
      chk("rst_read_data", read_data, 0);
      chk("rst_hit_count", hit_count, 0);
      chk("rst_miss_count", miss_count, 0);
      step();
      rst = 1'b1;

      for (int i = 0; i < NV; i++) begin
         mem_r_en = vecs[i].r; mem_w_en = vecs[i].w;
         address = vecs[i].addr; write_data = vecs[i].wd;
         cache_hit = vecs[i].hit; cache_data = vecs[i].cdata;
         sram_ready = vecs[i].srdy; sram_read_data = vecs[i].srdata;
         @(negedge clk);
         chk($sformatf("v%0d_ready", i), ready, vecs[i].e_ready);
         chk($sformatf("v%0d_read_data", i), read_data, vecs[i].e_rdata);
         chk($sformatf("v%0d_cache_address", i), cache_address, vecs[i].e_caddr);
         chk($sformatf("v%0d_sram_r_en", i), sram_r_en, vecs[i].e_sr);
         chk($sformatf("v%0d_sram_w_en", i), sram_w_en, vecs[i].e_sw);
         chk($sformatf("v%0d_sram_address", i), sram_address, vecs[i].e_saddr);
         chk($sformatf("v%0d_sram_write_data", i), sram_write_data, vecs[i].e_swd);
         chk($sformatf("v%0d_cache_u_en", i), cache_u_en, vecs[i].e_uen);
         chk($sformatf("v%0d_cache_invalid", i), cache_invalid, vecs[i].e_inv);
         chk($sformatf("v%0d_hit_count", i), hit_count, vecs[i].e_hc);
         chk($sformatf("v%0d_miss_count", i), miss_count, vecs[i].e_mc);
         step();
      end

      // reset three cycles into a read miss, then restart the same read
      idle_inputs();
      mem_r_en = 1; address = 32'h600;
      step();
      step();
      step();
      step();
      #2;
      sram_ready = 1;
      sram_read_data = 64'h0BAD0BAD_0BAD0BAD;
      rst = 1'b0;
      #1;
      chk("abort_sram_r_en", sram_r_en, 0);
      chk("abort_cache_u_en", cache_u_en, 0);
      chk("abort_ready", ready, 1);
      chk("abort_miss_count", miss_count, 0);
      chk("abort_hit_count", hit_count, 0);
      sram_ready = 0;
      step();
      chk("abort_state_idle_r_en", sram_r_en, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("restart_accept_ready", ready, 0);
      step();
      @(negedge clk);
      chk("restart_sram_r_en", sram_r_en, 1);
      chk("restart_sram_address", sram_address, 32'h600);
      chk("restart_miss_count", miss_count, 1);
      step();
      sram_ready = 1;
      sram_read_data = 64'hCAFEF00D_12345678;
      @(negedge clk);
      chk("restart_cache_u_en", cache_u_en, 1);
      chk("restart_read_data_off0", read_data, 32'hCAFEF00D);
      chk("restart_ready", ready, 1);
      step();
      idle_inputs();
      @(negedge clk);
      chk("restart_sram_r_en_drop", sram_r_en, 0);
      chk("restart_cache_u_en_drop", cache_u_en, 0);

      // hit counter saturation at 2^CW-1
      mem_r_en = 1; address = 32'h700; cache_hit = 1; cache_data = 32'h0000_0700;
      for (int k = 0; k < 5; k++) step();
      idle_inputs();
      @(negedge clk);
      chk("sat_hit_count", hit_count, 3);
      chk("sat_miss_count", miss_count, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
